// File: rtl/shift_pkg.sv
// Shared mode and FSM encodings for the shift/LFSR engine and its step logic.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step function: next register value and outgoing serial bit.
module shift_step
  import shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic [WIDTH-1:0] reg_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic             d_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] next_o,
  output logic             ser_o
);

  always_comb begin
    next_o = reg_i;
    ser_o  = ser_i;
    case (mode_i)
      MODE_SHIFT: begin
        if (dir_i) begin
          next_o = {reg_i[WIDTH-2:0], d_i};
          ser_o  = reg_i[WIDTH-1];
        end else begin
          next_o = {d_i, reg_i[WIDTH-1:1]};
          ser_o  = reg_i[0];
        end
      end
      MODE_ROTATE: begin
        if (dir_i) begin
          next_o = {reg_i[WIDTH-2:0], reg_i[WIDTH-1]};
          ser_o  = reg_i[WIDTH-1];
        end else begin
          next_o = {reg_i[0], reg_i[WIDTH-1:1]};
          ser_o  = reg_i[0];
        end
      end
      MODE_LFSR: begin
        // All-zero is the LFSR lock-up state; reseed instead of stepping.
        if (reg_i == '0) begin
          next_o = SEED;
        end else begin
          next_o = {reg_i[WIDTH-2:0], ^(reg_i & TAPS)};
        end
        ser_o = reg_i[WIDTH-1];
      end
      default: begin
        next_o = reg_i;
        ser_o  = ser_i;
      end
    endcase
  end

endmodule

// File: rtl/shift_lfsr_engine.sv
// Multi-mode shift/rotate/LFSR register with parallel load, single steps and counted bursts.
module shift_lfsr_engine
  import shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic             d_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [CNTW-1:0]  count_i,
  output logic [WIDTH-1:0] reg_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             ser_q, ser_d;
  logic             step;
  logic [WIDTH-1:0] step_reg;
  logic             step_ser;

  shift_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_step (
    .reg_i  (reg_q),
    .mode_i (mode_i),
    .dir_i  (dir_i),
    .d_i    (d_i),
    .ser_i  (ser_q),
    .next_o (step_reg),
    .ser_o  (step_ser)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      reg_q   <= (mode_i == MODE_LFSR) ? SEED : '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      ser_q   <= ser_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (load_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              state_d = ST_RUN;
              cnt_d   = count_i;
            end else begin
              state_d = ST_DONE;
            end
          end else if (en_i) begin
            step = 1'b1;
          end
        end
        ST_RUN: begin
          step  = 1'b1;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Load overrides the register but leaves the serial bit from the last step.
  always_comb begin
    reg_d = reg_q;
    ser_d = ser_q;
    if (load_i) begin
      reg_d = data_i;
    end else if (step) begin
      reg_d = step_reg;
      ser_d = step_ser;
    end
  end

  always_comb begin
    reg_o    = reg_q;
    serial_o = ser_q;
    busy_o   = (state_q == ST_RUN);
    done_o   = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_shift_lfsr_engine.sv
// Directed and randomized checks of shift_lfsr_engine against a behavioural model.
module tb_shift_lfsr_engine;

  localparam int         WIDTH = 8;
  localparam int         CNTW  = 4;
  localparam logic [7:0] TAPS  = 8'hB8;
  localparam logic [7:0] SEED  = 8'h01;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       mode_i;
  logic             dir_i;
  logic             d_i;
  logic             load_i;
  logic [WIDTH-1:0] data_i;
  logic             en_i;
  logic             start_i;
  logic [CNTW-1:0]  count_i;
  logic [WIDTH-1:0] reg_o;
  logic             serial_o;
  logic             busy_o;
  logic             done_o;

  always #5 clk_i = ~clk_i;

  shift_lfsr_engine #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .CNTW  (CNTW)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mode_i   (mode_i),
    .dir_i    (dir_i),
    .d_i      (d_i),
    .load_i   (load_i),
    .data_i   (data_i),
    .en_i     (en_i),
    .start_i  (start_i),
    .count_i  (count_i),
    .reg_o    (reg_o),
    .serial_o (serial_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: register value, serial bit, steps left in burst, done flag.
  logic [7:0] m_reg;
  logic       m_ser;
  int         m_rem;
  logic       m_done;

  task automatic m_step();
    int v;
    int fb;
    v = int'(m_reg);
    case (mode_i)
      2'd0: begin
        if (dir_i) begin
          m_ser = 1'((v >> 7) & 1);
          v = ((v << 1) | int'(d_i)) & 255;
        end else begin
          m_ser = 1'(v & 1);
          v = (v >> 1) | (int'(d_i) << 7);
        end
      end
      2'd1: begin
        if (dir_i) begin
          m_ser = 1'((v >> 7) & 1);
          v = ((v << 1) | int'(m_ser)) & 255;
        end else begin
          m_ser = 1'(v & 1);
          v = (v >> 1) | (int'(m_ser) << 7);
        end
      end
      2'd2: begin
        m_ser = 1'((v >> 7) & 1);
        if (v == 0) begin
          v = int'(SEED);
        end else begin
          fb = $countones(8'(v) & TAPS) % 2;
          v = ((v << 1) | fb) & 255;
        end
      end
      default: ;
    endcase
    m_reg = 8'(v);
  endtask

  task automatic m_update();
    if (rst_i) begin
      m_reg  = (mode_i == 2'd2) ? SEED : 8'h00;
      m_ser  = 1'b0;
      m_rem  = 0;
      m_done = 1'b0;
    end else if (load_i) begin
      m_reg  = data_i;
      m_rem  = 0;
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_step();
      m_rem--;
      m_done = (m_rem == 0);
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start_i) begin
      if (count_i > 0) m_rem = int'(count_i);
      else m_done = 1'b1;
    end else if (en_i) begin
      m_step();
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    m_update();
    #1;
    chk("reg_o", 32'(reg_o), 32'(m_reg));
    chk("serial_o", 32'(serial_o), 32'(m_ser));
    chk("busy_o", 32'(busy_o), 32'(m_rem > 0));
    chk("done_o", 32'(done_o), 32'(m_done));
  endtask

  task automatic quiet();
    rst_i = 1'b0; load_i = 1'b0; en_i = 1'b0; start_i = 1'b0;
  endtask

  initial begin
    logic [7:0] e_reg [3] = '{8'h4B, 8'h97, 8'h2F};
    logic       e_ser [3] = '{1'b1, 1'b0, 1'b1};
    int busy_n, done_n, steps, first_hit;

    quiet();
    mode_i = 2'd0; dir_i = 1'b1; d_i = 1'b1; data_i = '0; count_i = '0;
    m_reg = '0; m_ser = 1'b0; m_rem = 0; m_done = 1'b0;
    #2;

    // Reset in SHIFT mode
    rst_i = 1'b1;
    cycle();
    chk("rst_reg", 32'(reg_o), 32'h00);
    chk("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;

    // Load A5, SHIFT left, d=1, burst of 3
    load_i = 1'b1; data_i = 8'hA5;
    cycle();
    load_i = 1'b0;
    start_i = 1'b1; count_i = 4'd3;
    cycle();
    start_i = 1'b0;
    busy_n = int'(busy_o); done_n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i < 3) begin
        chk("burst3_reg", 32'(reg_o), 32'(e_reg[i]));
        chk("burst3_ser", 32'(serial_o), 32'(e_ser[i]));
      end
      busy_n += int'(busy_o);
      done_n += int'(done_o);
    end
    chk("burst3_busy_cycles", 32'(busy_n), 3);
    chk("burst3_done_cycles", 32'(done_n), 1);

    // ROTATE right then left
    load_i = 1'b1; data_i = 8'h81;
    cycle();
    load_i = 1'b0; mode_i = 2'd1; dir_i = 1'b0; en_i = 1'b1;
    cycle();
    chk("rotr_reg", 32'(reg_o), 32'hC0);
    chk("rotr_ser", 32'(serial_o), 1);
    dir_i = 1'b1;
    cycle();
    en_i = 1'b0;
    chk("rotl_reg", 32'(reg_o), 32'h81);

    // LFSR period from reset seed using bursts of 15
    mode_i = 2'd2; rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("lfsr_rst_reg", 32'(reg_o), 32'h01);
    steps = 0; first_hit = 0;
    for (int b = 0; b < 17; b++) begin
      start_i = 1'b1; count_i = 4'd15;
      cycle();
      start_i = 1'b0;
      for (int j = 0; j < 15; j++) begin
        cycle();
        steps++;
        if (reg_o == 8'h01 && first_hit == 0) first_hit = steps;
      end
      cycle();
    end
    chk("lfsr_period", 32'(first_hit), 255);

    // Lock-up recovery and N=0 burst
    load_i = 1'b1; data_i = 8'h00;
    cycle();
    load_i = 1'b0; en_i = 1'b1;
    cycle();
    en_i = 1'b0;
    chk("lfsr_recover", 32'(reg_o), 32'h01);
    start_i = 1'b1; count_i = 4'd0;
    cycle();
    start_i = 1'b0;
    chk("n0_done", 32'(done_o), 1);
    chk("n0_reg", 32'(reg_o), 32'h01);
    cycle();
    chk("n0_done_clr", 32'(done_o), 0);

    // Reset mid-burst
    mode_i = 2'd0; dir_i = 1'b1; d_i = 1'b0;
    load_i = 1'b1; data_i = 8'h55;
    cycle();
    load_i = 1'b0; start_i = 1'b1; count_i = 4'd8;
    cycle();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("rstmid_reg", 32'(reg_o), 32'h00);
    chk("rstmid_busy", 32'(busy_o), 0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin cycle(); done_n += int'(done_o); end
    chk("rstmid_no_done", 32'(done_n), 0);

    // Load mid-burst
    load_i = 1'b1; data_i = 8'hF0;
    cycle();
    load_i = 1'b0; start_i = 1'b1; count_i = 4'd8;
    cycle();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    load_i = 1'b1; data_i = 8'h3C;
    cycle();
    load_i = 1'b0;
    chk("ldmid_reg", 32'(reg_o), 32'h3C);
    chk("ldmid_busy", 32'(busy_o), 0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin cycle(); done_n += int'(done_o); end
    chk("ldmid_no_done", 32'(done_n), 0);

    // Restart while busy is ignored
    start_i = 1'b1; count_i = 4'd5;
    cycle();
    busy_n = int'(busy_o); done_n = 0;
    count_i = 4'd2;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) start_i = 1'b0;
      cycle();
      busy_n += int'(busy_o);
      done_n += int'(done_o);
    end
    chk("restart_busy_cycles", 32'(busy_n), 5);
    chk("restart_done_cycles", 32'(done_n), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_i   = ($urandom_range(0, 63) == 0);
      load_i  = ($urandom_range(0, 15) == 0);
      start_i = ($urandom_range(0, 3) == 0);
      en_i    = 1'($urandom);
      mode_i  = 2'($urandom);
      dir_i   = 1'($urandom);
      d_i     = 1'($urandom);
      data_i  = 8'($urandom);
      count_i = 4'($urandom_range(0, 15));
      cycle();
    end
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
